preg_free_list: RTL
===================

Name: preg_free_list

Overview:
- Circular FIFO of unallocated physical register tags, sitting directly upstream of the rename table.
- Supplies the new destination tag (rd_tag) when rename renames rd.
- Takes back the displaced old tag (rd_old_tag) when the owning instruction commits from the ROB.
- Single allocate and single free per cycle. No flush/checkpoint support in this revision.

Parameters:
- PREG_WIDTH, 6, width of a physical register tag.
- NUM_PREG, 64, total physical registers.
- NUM_AREG, 32, architectural registers; tags 0..NUM_AREG-1 are mapped at reset.
- FL_DEPTH, NUM_PREG-NUM_AREG (32), FIFO capacity; maximum number of simultaneously free tags.
- CNT_WIDTH, 6, width of free_count; must hold the value FL_DEPTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- alloc_req  input  1  rename requests one tag this cycle.
- alloc_valid  output  1  a tag is available (list not empty).
- alloc_tag  output  PREG_WIDTH  tag at head; valid when alloc_valid.
- alloc_fire  output  1  alloc_req && alloc_valid; head pops at this edge.
- free_valid  input  1  commit returns one tag this cycle.
- free_tag  input  PREG_WIDTH  tag being returned (the committed instruction's rd_old_tag).
- free_count  output  CNT_WIDTH  number of free tags currently held.
- empty  output  1  free_count == 0.
- full  output  1  free_count == FL_DEPTH.
- overflow_err  output  1  sticky: a free was dropped because the list was full.
- underflow_err  output  1  sticky: alloc_req was asserted while empty.

Behaviour:
- Storage: mem[0..FL_DEPTH-1] of PREG_WIDTH bits, plus head and tail pointers of log2(FL_DEPTH) bits and a count register.
- Pointers wrap modulo FL_DEPTH. FL_DEPTH must be a power of two; this is checked by an elaboration-time assertion.
- Reset (rst=1 at clock edge):
  - mem[i] = NUM_AREG+i.
  - head=0, tail=0, count=FL_DEPTH.
  - overflow_err=0, underflow_err=0.
  - After reset: full=1, empty=0, alloc_valid=1, alloc_tag=NUM_AREG (32), alloc_fire=0 unless alloc_req.
  - Reset has priority over any alloc or free in the same cycle.
- Read path is combinational, zero latency:
  - alloc_tag = mem[head]; alloc_valid = !empty; alloc_fire = alloc_req & alloc_valid.
  - Rename consumes alloc_tag in the same cycle it asserts alloc_req.
- Allocate: on an edge with alloc_fire=1, head <= head+1 and count decrements.
- Free: accepted when free_valid=1, free_tag != 0, and the list is not full.
  - On acceptance: mem[tail] <= free_tag, tail <= tail+1, count increments.
  - Tag 0 is permanently bound to x0: a free of tag 0 is silently dropped and raises no error.
- Simultaneous accepted alloc and free: both pointers advance and count is unchanged.
- No bypass when empty: if empty and a free arrives, alloc_valid stays 0 that cycle. The freed tag becomes allocatable on the next cycle.
- Full: a non-zero free while full is dropped and overflow_err <= 1. This also applies when an alloc_fire occurs in the same cycle, because the full check uses registered state.
- Empty: alloc_req while empty gives alloc_fire=0 and sets underflow_err <= 1. State is unchanged apart from any accepted free.
- Error flags clear only on rst.
- free_count, empty and full are derived from the registered count and update the cycle after the edge.
- Duplicate-tag detection is not performed; upstream guarantees each tag is freed at most once.

Test Plan:
- Reset, no activity -> alloc_valid=1, alloc_tag=32, free_count=32, full=1, empty=0, both error flags 0.
- alloc_req held for 32 cycles -> alloc_tag sequence 32,33,...,63, one per cycle; then empty=1, free_count=0, alloc_valid=0. A 33rd request sets underflow_err=1 with free_count staying 0.
- From empty, free 40 then 5 on consecutive cycles, then allocate twice -> allocated tags 40 then 5 (FIFO order). alloc_valid is 0 in the cycle the first free is presented.
- Allocate 4 tags, then hold alloc_req and free_valid together for 10 cycles with tags 50..59 -> free_count stays 28 throughout. Tail and head wrap correctly when the bench runs 40+ cycles.
- At full, free_valid with free_tag=7 -> overflow_err=1, count stays 32. Then free_tag=0 at any fill level -> dropped, count unchanged, no error.
- Mid-sequence: after 10 allocs, assert rst together with alloc_req and free_valid -> next cycle free_count=32, alloc_tag=32, error flags cleared.

Source files
------------

// File: rtl/preg_free_list_if.sv
// Rename/commit-facing bundle of the physical register free list:
// allocate handshake, free port, and occupancy/error status.
interface preg_free_list_if #(
  parameter int PREG_WIDTH = 6,
  parameter int CNT_WIDTH  = 6
);
  logic                  alloc_req;
  logic                  alloc_valid;
  logic [PREG_WIDTH-1:0] alloc_tag;
  logic                  alloc_fire;
  logic                  free_valid;
  logic [PREG_WIDTH-1:0] free_tag;
  logic [CNT_WIDTH-1:0]  free_count;
  logic                  empty;
  logic                  full;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output alloc_req, free_valid, free_tag,
    input  alloc_valid, alloc_tag, alloc_fire,
    input  free_count, empty, full, overflow_err, underflow_err
  );

  modport slave (
    input  alloc_req, free_valid, free_tag,
    output alloc_valid, alloc_tag, alloc_fire,
    output free_count, empty, full, overflow_err, underflow_err
  );
endinterface

// File: rtl/preg_free_list.sv
// Circular FIFO of unallocated physical register tags feeding rename;
// commit returns displaced tags. One allocate and one free per cycle.
module preg_free_list #(
  parameter int PREG_WIDTH = 6,
  parameter int NUM_PREG   = 64,
  parameter int NUM_AREG   = 32,
  parameter int FL_DEPTH   = NUM_PREG - NUM_AREG,
  parameter int CNT_WIDTH  = 6
) (
  input  logic             clk,
  input  logic             rst,
  preg_free_list_if.slave  fl
);

  localparam int PTR_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

  if ((FL_DEPTH & (FL_DEPTH - 1)) != 0) begin : g_depth_pow2_chk
    $error("preg_free_list: FL_DEPTH must be a power of two");
  end
  if (FL_DEPTH >= (1 << CNT_WIDTH)) begin : g_cnt_width_chk
    $error("preg_free_list: CNT_WIDTH cannot hold FL_DEPTH");
  end

  logic [PREG_WIDTH-1:0] mem [FL_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_WIDTH-1:0]  count;
  logic                  ovf_err;
  logic                  unf_err;

  logic is_empty;
  logic is_full;
  logic fire;
  logic free_ok;

  // Status comes from registered count only, so a free presented while
  // empty does not bypass to the allocate side in the same cycle.
  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_WIDTH'(FL_DEPTH));
  assign fire     = fl.alloc_req & ~is_empty;
  assign free_ok  = fl.free_valid & (fl.free_tag != '0) & ~is_full;

  assign fl.alloc_valid   = ~is_empty;
  assign fl.alloc_tag     = mem[head];
  assign fl.alloc_fire    = fire;
  assign fl.free_count    = count;
  assign fl.empty         = is_empty;
  assign fl.full          = is_full;
  assign fl.overflow_err  = ovf_err;
  assign fl.underflow_err = unf_err;

  // Tag storage: reset loads the tags not mapped by the architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= PREG_WIDTH'(NUM_AREG + i);
      end
    end else if (free_ok) begin
      mem[tail] <= fl.free_tag;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= CNT_WIDTH'(FL_DEPTH);
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (fire)    head <= head + 1'b1;
      if (free_ok) tail <= tail + 1'b1;
      case ({fire, free_ok})
        2'b10:   count <= count - 1'b1;
        2'b01:   count <= count + 1'b1;
        default: count <= count;
      endcase
      // Tag 0 is hard-wired to x0; returning it is not an overflow.
      if (fl.free_valid && (fl.free_tag != '0) && is_full) ovf_err <= 1'b1;
      if (fl.alloc_req && is_empty)                       unf_err <= 1'b1;
    end
  end

endmodule
